// File: rtl/mem_stage_lsu.sv
// Memory stage with load/store unit: EX->MEM register, variable-latency
// load responses with a wait/hold buffer, lane extraction and forwarding.
module mem_stage_lsu #(
  parameter int XLEN   = 64,
  parameter int RF_AW  = 5,
  parameter int LANE_W = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [LANE_W-1:0] ex_addr_lo,
  input  logic              ex_rf_we,
  input  logic [RF_AW-1:0]  ex_rf_waddr,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [31:0]       ex_inst,
  input  logic              dresp_valid,
  input  logic [XLEN-1:0]   dresp_rdata,
  input  logic              dresp_err,
  output logic              stall_req,
  output logic              wb_valid,
  output logic              wb_rf_we,
  output logic [RF_AW-1:0]  wb_rf_waddr,
  output logic [XLEN-1:0]   wb_rf_wdata,
  output logic [XLEN-1:0]   wb_pc,
  output logic [31:0]       wb_inst,
  output logic [1:0]        wb_exc,
  output logic              fwd_rf_we,
  output logic [RF_AW-1:0]  fwd_rf_waddr,
  output logic [XLEN-1:0]   fwd_wdata,
  output logic              fwd_data_ok
);

  typedef struct packed {
    logic              valid;
    logic              load;
    logic [1:0]        size;
    logic              uns;
    logic [LANE_W-1:0] lo;
    logic              rf_we;
    logic [RF_AW-1:0]  waddr;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   pc;
    logic [31:0]       inst;
  } mem_t;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  mem_t            st_q, st_d;
  state_e          state_q;
  logic [XLEN-1:0] buf_q;
  logic            buf_err_q;

  logic            mis, ld_act, hold, adv, serr, sgn;
  logic [XLEN-1:0] src, sh, mask, ld_data, wdata;
  logic [1:0]      exc;

  always_comb begin
    st_d = st_q;
    if (stall_mem && !stall_wb) begin
      st_d = '0;
    end else if (!stall_mem) begin
      st_d.valid  = ex_valid;
      st_d.load   = ex_load;
      st_d.size   = ex_size;
      st_d.uns    = ex_unsigned;
      st_d.lo     = ex_addr_lo;
      st_d.rf_we  = ex_rf_we;
      st_d.waddr  = ex_rf_waddr;
      st_d.result = ex_result;
      st_d.pc     = ex_pc;
      st_d.inst   = ex_inst;
    end
  end

  always_comb begin
    mis = 1'b0;
    if (st_q.valid && st_q.load) begin
      unique case (st_q.size)
        2'd0:    mis = 1'b0;
        2'd1:    mis = st_q.lo[0];
        2'd2:    mis = |st_q.lo[1:0];
        default: mis = (XLEN == 32) || (|st_q.lo);
      endcase
    end
  end

  assign ld_act    = st_q.valid && st_q.load && !mis;
  assign hold      = (state_q == HOLD);
  assign adv       = !(stall_mem && stall_wb);
  assign src       = hold ? buf_q : dresp_rdata;
  assign serr      = hold ? buf_err_q : dresp_err;
  assign stall_req = ld_act && !dresp_valid && !hold;

  assign sh = src >> {st_q.lo, 3'b000};

  always_comb begin
    unique case (st_q.size)
      2'd0: begin
        mask = XLEN'(8'hFF);
        sgn  = sh[7];
      end
      2'd1: begin
        mask = XLEN'(16'hFFFF);
        sgn  = sh[15];
      end
      2'd2: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sgn  = sh[31];
      end
      default: begin
        mask = '1;
        sgn  = 1'b0;
      end
    endcase
    ld_data = (sh & mask) | ({XLEN{sgn && !st_q.uns}} & ~mask);
  end

  // an unstalled bubble or advance both retire the load from this stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= '0;
      state_q   <= IDLE;
      buf_q     <= '0;
      buf_err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      unique case (state_q)
        IDLE: begin
          if (ld_act && !adv) begin
            if (dresp_valid) begin
              buf_q     <= dresp_rdata;
              buf_err_q <= dresp_err;
              state_q   <= HOLD;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dresp_valid) begin
            buf_q     <= dresp_rdata;
            buf_err_q <= dresp_err;
            state_q   <= adv ? IDLE : HOLD;
          end else if (adv) begin
            state_q <= IDLE;
          end
        end
        HOLD: if (adv) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign exc   = mis ? 2'd1 :
                 (ld_act && !stall_req && serr) ? 2'd2 : 2'd0;
  assign wdata = ld_act ? ld_data : st_q.result;

  assign wb_valid     = st_q.valid && !stall_req;
  assign wb_exc       = wb_valid ? exc : 2'd0;
  assign wb_rf_we     = wb_valid && st_q.rf_we && (exc == 2'd0);
  assign wb_rf_waddr  = st_q.waddr;
  assign wb_rf_wdata  = wdata;
  assign wb_pc        = st_q.pc;
  assign wb_inst      = st_q.inst;
  assign fwd_rf_we    = st_q.valid && st_q.rf_we;
  assign fwd_rf_waddr = st_q.waddr;
  assign fwd_wdata    = wdata;
  assign fwd_data_ok  = !stall_req;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios plus a random run scored
// against a byte-level load model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall_mem, stall_wb;
  logic        ex_valid, ex_load, ex_unsigned, ex_rf_we;
  logic [1:0]  ex_size;
  logic [2:0]  ex_addr_lo;
  logic [4:0]  ex_rf_waddr;
  logic [63:0] ex_result, ex_pc;
  logic [31:0] ex_inst;
  logic        dresp_valid, dresp_err;
  logic [63:0] dresp_rdata;
  logic        stall_req, wb_valid, wb_rf_we, fwd_rf_we, fwd_data_ok;
  logic [4:0]  wb_rf_waddr, fwd_rf_waddr;
  logic [63:0] wb_rf_wdata, wb_pc, fwd_wdata;
  logic [31:0] wb_inst;
  logic [1:0]  wb_exc;

  mem_stage_lsu u_dut (
    .clk(clk), .rst_n(rst_n),
    .stall_mem(stall_mem), .stall_wb(stall_wb),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_addr_lo(ex_addr_lo),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_result(ex_result), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
    .dresp_err(dresp_err),
    .stall_req(stall_req), .wb_valid(wb_valid), .wb_rf_we(wb_rf_we),
    .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
    .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_exc(wb_exc),
    .fwd_rf_we(fwd_rf_we), .fwd_rf_waddr(fwd_rf_waddr),
    .fwd_wdata(fwd_wdata), .fwd_data_ok(fwd_data_ok)
  );

  logic        s_valid, s_load, s_dv;
  logic [1:0]  s_size, s_lo;
  logic [31:0] s_result, s_rdata;
  logic        t_stall, t_valid, t_we, t_fwe, t_ok;
  logic [4:0]  t_wa, t_fwa;
  logic [31:0] t_wd, t_pc, t_inst, t_fwd;
  logic [1:0]  t_exc;

  mem_stage_lsu #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .stall_mem(1'b0), .stall_wb(1'b0),
    .ex_valid(s_valid), .ex_load(s_load), .ex_size(s_size),
    .ex_unsigned(1'b0), .ex_addr_lo(s_lo),
    .ex_rf_we(1'b1), .ex_rf_waddr(5'd1),
    .ex_result(s_result), .ex_pc(32'd0), .ex_inst(32'd0),
    .dresp_valid(s_dv), .dresp_rdata(s_rdata), .dresp_err(1'b0),
    .stall_req(t_stall), .wb_valid(t_valid), .wb_rf_we(t_we),
    .wb_rf_waddr(t_wa), .wb_rf_wdata(t_wd),
    .wb_pc(t_pc), .wb_inst(t_inst), .wb_exc(t_exc),
    .fwd_rf_we(t_fwe), .fwd_rf_waddr(t_fwa),
    .fwd_wdata(t_fwd), .fwd_data_ok(t_ok)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  typedef struct packed {
    logic        valid;
    logic        load;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  lo;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] res;
    logic [63:0] pc;
    logic [31:0] inst;
  } ins_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [1:0]  exc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_x;
  bit   sb_on = 0;

  function automatic bit m_mis(ins_t i);
    int nb;
    nb = 1 << i.size;
    return i.valid && i.load && ((int'(i.lo) % nb) != 0);
  endfunction

  function automatic logic [63:0] m_load(ins_t i, logic [63:0] d);
    int nb;
    logic [63:0] v, m;
    nb = 1 << i.size;
    v  = d >> (8 * int'(i.lo));
    if (nb < 8) begin
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (!i.uns && v[8*nb-1]) v = v | ~m;
    end
    return v;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    int   nb;
    i.valid = ($urandom % 8) != 0;
    i.load  = $urandom % 2;
    i.size  = 2'($urandom % 4);
    i.uns   = $urandom % 2;
    nb      = 1 << i.size;
    i.lo    = 3'($urandom % 8);
    if (($urandom % 4) != 0) i.lo = i.lo & ~3'(nb - 1);
    i.we    = ($urandom % 4) != 0;
    i.wa    = 5'($urandom);
    i.res   = {$urandom, $urandom};
    i.pc    = {$urandom, $urandom};
    i.inst  = $urandom;
    return i;
  endfunction

  task automatic drive(ins_t i);
    ex_valid    = i.valid;
    ex_load     = i.load;
    ex_size     = i.size;
    ex_unsigned = i.uns;
    ex_addr_lo  = i.lo;
    ex_rf_we    = i.we;
    ex_rf_waddr = i.wa;
    ex_result   = i.res;
    ex_pc       = i.pc;
    ex_inst     = i.inst;
  endtask

  function automatic ins_t mk(logic ld, logic [1:0] sz, logic u,
                              logic [2:0] lo, logic [4:0] wa,
                              logic [63:0] res, logic [63:0] pc);
    ins_t i;
    i = '{valid: 1'b1, load: ld, size: sz, uns: u, lo: lo, we: 1'b1,
          wa: wa, res: res, pc: pc, inst: 32'h1000_0000 | 32'(pc)};
    return i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_on && wb_valid && !stall_wb) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got wb pc %h expected no retire", wb_pc);
      end else begin
        mon_x = sbq.pop_front();
        chk("sb_exc", 64'(wb_exc), 64'(mon_x.exc));
        chk("sb_we", 64'(wb_rf_we), 64'(mon_x.we));
        chk("sb_waddr", 64'(wb_rf_waddr), 64'(mon_x.wa));
        chk("sb_pc", wb_pc, mon_x.pc);
        chk("sb_inst", 64'(wb_inst), 64'(mon_x.inst));
        if (mon_x.exc != 2'd1) begin
          chk("sb_wdata", wb_rf_wdata, mon_x.wd);
          chk("sb_fwd", fwd_wdata, mon_x.wd);
        end
      end
    end
  end

  ins_t        slot, cur, nop;
  bit          got, gerr, isld, rnow, avail, xst, e_err;
  logic [63:0] gd, d;
  int          ext;
  exp_t        ex_e;

  initial begin
    nop = '0;
    rst_n = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
    dresp_valid = 1'b0; dresp_rdata = '0; dresp_err = 1'b0;
    s_valid = 1'b0; s_load = 1'b0; s_size = '0; s_lo = '0;
    s_result = '0; s_dv = 1'b0; s_rdata = '0;
    drive(nop);
    tick(); tick();
    @(negedge clk);
    chk("rst_wb_valid", 64'(wb_valid), 0);
    chk("rst_wdata", wb_rf_wdata, 0);
    chk("rst_stall", 64'(stall_req), 0);
    chk("rst_fwd_ok", 64'(fwd_data_ok), 1);
    chk("rst_exc", 64'(wb_exc), 0);
    chk("rst_fwd_we", 64'(fwd_rf_we), 0);
    tick();
    rst_n = 1'b1;

    // LW signed, response in the same cycle
    drive(mk(1, 2, 0, 4, 5'd3, 64'hDEAD, 64'h100));
    tick();
    drive(nop);
    dresp_valid = 1'b1; dresp_rdata = 64'h8123_4567_89AB_CDEF;
    @(negedge clk);
    chk("lw_stall", 64'(stall_req), 0);
    chk("lw_valid", 64'(wb_valid), 1);
    chk("lw_wdata", wb_rf_wdata, 64'hFFFF_FFFF_8123_4567);
    chk("lw_we", 64'(wb_rf_we), 1);
    chk("lw_waddr", 64'(wb_rf_waddr), 3);
    tick();

    // LBU, response three cycles late
    dresp_valid = 1'b0;
    drive(mk(1, 0, 1, 7, 5'd5, 64'h0, 64'h104));
    tick();
    drive(nop);
    stall_mem = 1'b1; stall_wb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lbu_stall", 64'(stall_req), 1);
      chk("lbu_fwd_ok", 64'(fwd_data_ok), 0);
      tick();
    end
    dresp_valid = 1'b1; stall_mem = 1'b0; stall_wb = 1'b0;
    @(negedge clk);
    chk("lbu_stall_end", 64'(stall_req), 0);
    chk("lbu_valid", 64'(wb_valid), 1);
    chk("lbu_wdata", wb_rf_wdata, 64'h81);
    chk("lbu_fwd_ok_end", 64'(fwd_data_ok), 1);
    tick();

    // LH misaligned: no wait
    dresp_valid = 1'b0;
    drive(mk(1, 1, 0, 1, 5'd6, 64'h0, 64'h108));
    tick();
    drive(nop);
    @(negedge clk);
    chk("mis_exc", 64'(wb_exc), 1);
    chk("mis_we", 64'(wb_rf_we), 0);
    chk("mis_stall", 64'(stall_req), 0);
    chk("mis_valid", 64'(wb_valid), 1);
    tick();

    // response buffered while held
    drive(mk(1, 3, 0, 0, 5'd7, 64'h0, 64'h10C));
    tick();
    drive(nop);
    dresp_valid = 1'b1; dresp_rdata = 64'h0123_4567_89AB_CDEF;
    stall_mem = 1'b1; stall_wb = 1'b1;
    @(negedge clk);
    chk("hold_wd0", wb_rf_wdata, 64'h0123_4567_89AB_CDEF);
    tick();
    dresp_valid = 1'b0; dresp_rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    chk("hold_wd1", wb_rf_wdata, 64'h0123_4567_89AB_CDEF);
    chk("hold_stall", 64'(stall_req), 0);
    tick();
    dresp_valid = 1'b1; dresp_rdata = 64'h5555_5555_5555_5555;
    tick();
    dresp_valid = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
    @(negedge clk);
    chk("hold_wd2", wb_rf_wdata, 64'h0123_4567_89AB_CDEF);
    chk("hold_valid", 64'(wb_valid), 1);
    tick();

    // ALU op, then a bubble
    drive(mk(0, 0, 0, 0, 5'd9, 64'h1234, 64'h110));
    tick();
    drive(nop);
    @(negedge clk);
    chk("alu_wdata", wb_rf_wdata, 64'h1234);
    chk("alu_fwd_ok", 64'(fwd_data_ok), 1);
    chk("alu_we", 64'(wb_rf_we), 1);
    chk("alu_fwd_we", 64'(fwd_rf_we), 1);
    tick();
    drive(mk(0, 0, 0, 0, 5'd10, 64'h9999, 64'h114));
    stall_mem = 1'b1; stall_wb = 1'b0;
    tick();
    stall_mem = 1'b0;
    drive(nop);
    @(negedge clk);
    chk("bub_valid", 64'(wb_valid), 0);
    chk("bub_we", 64'(wb_rf_we), 0);
    chk("bub_wdata", wb_rf_wdata, 0);
    chk("bub_pc", wb_pc, 0);
    chk("bub_inst", 64'(wb_inst), 0);
    chk("bub_waddr", 64'(wb_rf_waddr), 0);
    tick();

    // reset in WAIT, then a stray response
    drive(mk(1, 2, 0, 0, 5'd11, 64'h0, 64'h118));
    tick();
    drive(nop);
    stall_mem = 1'b1; stall_wb = 1'b1;
    @(negedge clk);
    chk("rw_stall", 64'(stall_req), 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; stall_mem = 1'b0; stall_wb = 1'b0;
    dresp_valid = 1'b1; dresp_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    chk("rw_stall_after", 64'(stall_req), 0);
    chk("rw_valid", 64'(wb_valid), 0);
    chk("rw_we", 64'(wb_rf_we), 0);
    chk("rw_wdata", wb_rf_wdata, 0);
    tick();
    dresp_valid = 1'b0;

    // XLEN=32 instance
    s_valid = 1'b1; s_load = 1'b1; s_size = 2'd3; s_lo = 2'd0;
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("x32_ld_exc", 64'(t_exc), 1);
    chk("x32_ld_we", 64'(t_we), 0);
    chk("x32_ld_stall", 64'(t_stall), 0);
    tick();
    s_valid = 1'b1; s_size = 2'd2; s_lo = 2'd0;
    tick();
    s_valid = 1'b0; s_dv = 1'b1; s_rdata = 32'h8000_0001;
    @(negedge clk);
    chk("x32_lw", 64'(t_wd), 64'h8000_0001);
    tick();
    s_valid = 1'b1; s_size = 2'd1; s_lo = 2'd2;
    tick();
    s_valid = 1'b0; s_rdata = 32'h8001_1234;
    @(negedge clk);
    chk("x32_lh", 64'(t_wd), 64'hFFFF_8001);
    chk("x32_lh_we", 64'(t_we), 1);
    tick();
    s_dv = 1'b0;

    // random run against the model
    rst_n = 1'b0;
    drive(nop);
    tick(); tick();
    rst_n = 1'b1;
    slot = '0; got = 0; gd = '0; gerr = 0;
    cur = rnd_ins();
    sb_on = 1;
    for (int c = 0; c < 1500; c++) begin
      ext         = $urandom % 4;
      dresp_valid = ($urandom % 3) == 0;
      dresp_rdata = {$urandom, $urandom};
      dresp_err   = ($urandom % 8) == 0;
      drive(cur);
      isld  = slot.valid && slot.load && !m_mis(slot);
      rnow  = isld && !got && dresp_valid;
      avail = got || rnow;
      d     = got ? gd : dresp_rdata;
      e_err = got ? gerr : dresp_err;
      xst   = isld && !avail;
      stall_mem = xst || ext == 0 || ext == 1;
      stall_wb  = xst || ext == 0;
      if (slot.valid && !xst && !stall_wb) begin
        ex_e.exc  = m_mis(slot) ? 2'd1 : (isld && e_err) ? 2'd2 : 2'd0;
        ex_e.we   = slot.we && ex_e.exc == 2'd0;
        ex_e.wa   = slot.wa;
        ex_e.wd   = isld ? m_load(slot, d) : slot.res;
        ex_e.pc   = slot.pc;
        ex_e.inst = slot.inst;
        sbq.push_back(ex_e);
      end
      @(negedge clk);
      chk("rnd_stall", 64'(stall_req), 64'(xst));
      chk("rnd_fwd_ok", 64'(fwd_data_ok), 64'(!xst));
      chk("rnd_fwd_we", 64'(fwd_rf_we), 64'(slot.valid && slot.we));
      @(posedge clk);
      if (stall_mem && stall_wb) begin
        if (isld && avail) begin
          got = 1; gd = d; gerr = e_err;
        end
      end else begin
        slot = stall_mem ? nop : cur;
        got  = 0;
        if (!stall_mem) cur = rnd_ins();
      end
      #1;
    end
    @(negedge clk);
    sb_on = 0;
    chk("sb_drain", 64'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
